// File: rtl/ldtu_ostage_pkg.sv
// Shared definitions for the LiTE-DTU output stage: mode encodings,
// default idle word and the active-lane clamp helper.
package ldtu_ostage_pkg;

    typedef enum logic [1:0] {
        MODE_DTU   = 2'b00,
        MODE_ATU   = 2'b01,
        MODE_SYNCH = 2'b10,
        MODE_IDLE  = 2'b11
    } mode_e;

    localparam logic [31:0] IDLE_WORD_DEFAULT = 32'hEAAAAAAA;

    // Active lane count limited to 1..nmax; zero behaves as a single lane.
    function automatic logic [3:0] clamp_nact(input logic [3:0] n, input logic [3:0] nmax);
        if (n == 4'd0) return 4'd1;
        if (n > nmax) return nmax;
        return n;
    endfunction

endpackage

// File: rtl/ldtu_ostage_nlane_if.sv
// Bus between the control unit / serialisers and the output stage.
// Optional: LDTU_OSTAGE_ALMOST_FULL_EN adds the almost_full flag.
//
// Handshake: write_signal and read_signal are single-cycle strobes sampled on
// CLK. There is no backpressure; a push while full is dropped and accounted
// (losing_data/drop_cnt), a pop while empty is ignored and flagged (underflow).
interface ldtu_ostage_nlane_if #(
    parameter int WIDTH  = 32,
    parameter int NLANES = 4
);
    logic                    flush_b;
    logic [1:0]              mode;
    logic                    synch;
    logic [WIDTH-1:0]        synch_pattern;
    logic [3:0]              n_act_lanes;
    logic                    write_signal;
    logic [WIDTH-1:0]        data_in;
    logic                    read_signal;
    logic [NLANES*WIDTH-1:0] data_atu;
    logic [NLANES*WIDTH-1:0] data_out;
    logic                    full_signal;
    logic                    empty_signal;
    logic                    losing_data;
    logic [7:0]              drop_cnt;
    logic                    underflow;
`ifdef LDTU_OSTAGE_ALMOST_FULL_EN
    logic                    almost_full;
`endif

    modport master (
        output flush_b, mode, synch, synch_pattern, n_act_lanes,
        output write_signal, data_in, read_signal, data_atu,
        input  data_out, full_signal, empty_signal, losing_data, drop_cnt, underflow
`ifdef LDTU_OSTAGE_ALMOST_FULL_EN
        , input almost_full
`endif
    );

    modport slave (
        input  flush_b, mode, synch, synch_pattern, n_act_lanes,
        input  write_signal, data_in, read_signal, data_atu,
        output data_out, full_signal, empty_signal, losing_data, drop_cnt, underflow
`ifdef LDTU_OSTAGE_ALMOST_FULL_EN
        , output almost_full
`endif
    );

endinterface

// File: rtl/ldtu_ostage_fifo.sv
// Circular word FIFO with registered full/empty, drop and underflow accounting.
// Optional: LDTU_OSTAGE_ALMOST_FULL_EN adds a registered almost_full flag.
module ldtu_ostage_fifo #(
    parameter int WIDTH     = 32,
    parameter int DEPTH     = 16,
    parameter int AF_THRESH = 12
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             flush_b,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             pop_ok,
    output logic             full,
    output logic             empty,
    output logic             losing_data,
    output logic [7:0]       drop_cnt,
    output logic             underflow
`ifdef LDTU_OSTAGE_ALMOST_FULL_EN
    , output logic           almost_full
`endif
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [AW:0]      count, count_nxt;
    logic             wr_ok, drop;

    // A pop in the same cycle frees the slot, so a write while full still lands.
    assign pop_ok  = rd_en && !empty && flush_b;
    assign wr_ok   = wr_en && (!full || pop_ok) && flush_b;
    assign drop    = wr_en && !wr_ok && flush_b;
    assign rd_data = mem[rd_ptr];

    // Next occupancy, used so the flags line up with the pointers.
    always_comb begin
        count_nxt = count;
        case ({wr_ok, pop_ok})
            2'b10:   count_nxt = count + 1'b1;
            2'b01:   count_nxt = count - 1'b1;
            default: count_nxt = count;
        endcase
    end

    // Storage array; contents need no reset since pointers define validity.
    always_ff @(posedge clk) begin
        if (wr_ok) mem[wr_ptr] <= wr_data;
    end

    // Pointers, occupancy, status and sticky error flags.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            wr_ptr <= '0; rd_ptr <= '0; count <= '0;
            full <= 1'b0; empty <= 1'b1;
            losing_data <= 1'b0; drop_cnt <= '0; underflow <= 1'b0;
`ifdef LDTU_OSTAGE_ALMOST_FULL_EN
            almost_full <= 1'b0;
`endif
        end else if (!flush_b) begin
            wr_ptr <= '0; rd_ptr <= '0; count <= '0;
            full <= 1'b0; empty <= 1'b1;
            losing_data <= 1'b0; drop_cnt <= '0; underflow <= 1'b0;
`ifdef LDTU_OSTAGE_ALMOST_FULL_EN
            almost_full <= 1'b0;
`endif
        end else begin
            if (wr_ok)  wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok) rd_ptr <= rd_ptr + 1'b1;
            count <= count_nxt;
            full  <= (count_nxt == (AW+1)'(DEPTH));
            empty <= (count_nxt == '0);
            if (drop) begin
                losing_data <= 1'b1;
                if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
            end
            if (rd_en && empty) underflow <= 1'b1;
`ifdef LDTU_OSTAGE_ALMOST_FULL_EN
            almost_full <= (count_nxt >= (AW+1)'(AF_THRESH));
`endif
        end
    end

endmodule

// File: rtl/ldtu_ostage_nlane.sv
// LiTE-DTU output stage: FIFO plus N-lane output mux (DTU/ATU/SYNCH/IDLE).
// Optional: LDTU_OSTAGE_ALMOST_FULL_EN exposes the FIFO almost_full flag.
module ldtu_ostage_nlane
    import ldtu_ostage_pkg::*;
#(
    parameter int          WIDTH     = 32,
    parameter int          DEPTH     = 16,
    parameter int          NLANES    = 4,
    parameter logic [31:0] IDLE_WORD = IDLE_WORD_DEFAULT,
    parameter int          AF_THRESH = 12
) (
    input logic CLK,
    input logic rst_b,
    ldtu_ostage_nlane_if.slave bus
);
    localparam logic [WIDTH-1:0] IDLE_W = WIDTH'(IDLE_WORD);

    mode_e                   eff_mode, prev_mode;
    logic [3:0]              nact;
    logic                    pop_req, pop_ok, entering;
    logic [WIDTH-1:0]        rd_data;
    logic [2:0]              lane_ptr, cur_ptr;
    logic [3:0]              nxt_ptr;
    logic [NLANES*WIDTH-1:0] lanes;

    assign eff_mode = bus.synch ? MODE_SYNCH : mode_e'(bus.mode);
    assign nact     = clamp_nact(bus.n_act_lanes, 4'(NLANES));
    assign pop_req  = bus.read_signal && (eff_mode == MODE_DTU);
    assign entering = (eff_mode == MODE_DTU) && (prev_mode != MODE_DTU);
    assign bus.data_out = lanes;

    ldtu_ostage_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AF_THRESH(AF_THRESH)) u_fifo (
        .clk         (CLK),
        .rst_b       (rst_b),
        .flush_b     (bus.flush_b),
        .wr_en       (bus.write_signal),
        .wr_data     (bus.data_in),
        .rd_en       (pop_req),
        .rd_data     (rd_data),
        .pop_ok      (pop_ok),
        .full        (bus.full_signal),
        .empty       (bus.empty_signal),
        .losing_data (bus.losing_data),
        .drop_cnt    (bus.drop_cnt),
        .underflow   (bus.underflow)
`ifdef LDTU_OSTAGE_ALMOST_FULL_EN
        , .almost_full (bus.almost_full)
`endif
    );

    // Target lane of this cycle's pop; a stale pointer past nact restarts at lane 0.
    always_comb begin
        cur_ptr = lane_ptr;
        if (entering || ({1'b0, lane_ptr} >= nact)) cur_ptr = '0;
        nxt_ptr = {1'b0, cur_ptr} + 4'd1;
    end

    // Lane registers, round-robin pointer and mode-entry tracking.
    always_ff @(posedge CLK or negedge rst_b) begin
        if (!rst_b) begin
            lanes     <= {NLANES{IDLE_W}};
            lane_ptr  <= '0;
            prev_mode <= MODE_DTU;
        end else if (!bus.flush_b) begin
            lanes     <= {NLANES{IDLE_W}};
            lane_ptr  <= '0;
            prev_mode <= MODE_DTU;
        end else begin
            prev_mode <= eff_mode;
            case (eff_mode)
                MODE_DTU: begin
                    for (int i = 0; i < NLANES; i++) begin
                        if (entering || (4'(i) >= nact)) lanes[i*WIDTH +: WIDTH] <= IDLE_W;
                    end
                    if (pop_ok) begin
                        lanes[cur_ptr*WIDTH +: WIDTH] <= rd_data;
                        lane_ptr <= (nxt_ptr >= nact) ? 3'd0 : nxt_ptr[2:0];
                    end else begin
                        lane_ptr <= cur_ptr;
                    end
                end
                MODE_ATU:   lanes <= bus.data_atu;
                MODE_SYNCH: lanes <= {NLANES{bus.synch_pattern}};
                default:    lanes <= {NLANES{IDLE_W}};
            endcase
        end
    end

endmodule

// File: tb/tb_ldtu_ostage_nlane.sv
// Directed bench for ldtu_ostage_nlane (default build; the almost_full check
// is compiled only with LDTU_OSTAGE_ALMOST_FULL_EN).
module tb_ldtu_ostage_nlane;
    localparam logic [31:0] I = 32'hEAAAAAAA;

    logic clk = 1'b0;
    logic rst_b;
    int   n_assert = 0;
    int   n_fail   = 0;

    ldtu_ostage_nlane_if #(.WIDTH(32), .NLANES(4)) bus ();

    ldtu_ostage_nlane #(.WIDTH(32), .DEPTH(16), .NLANES(4)) dut (
        .CLK   (clk),
        .rst_b (rst_b),
        .bus   (bus.slave)
    );

    // clock / reset block
    always #5 clk = ~clk;

    typedef struct {
        logic         wr;
        logic         rd;
        logic [31:0]  din;
        logic [127:0] exp_lanes;
        logic         exp_empty;
        logic         exp_full;
    } vec_t;

    vec_t vt[16];

    function automatic logic [127:0] lanes4(input logic [31:0] l0, l1, l2, l3);
        return {l3, l2, l1, l0};
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_b = 1'b0;
        tick();
        tick();
        rst_b = 1'b1;
    endtask

    task automatic push(input logic [31:0] d);
        bus.write_signal = 1'b1;
        bus.data_in = d;
        tick();
        bus.write_signal = 1'b0;
    endtask

    task automatic pop();
        bus.read_signal = 1'b1;
        tick();
        bus.read_signal = 1'b0;
    endtask

    initial begin
        rst_b = 1'b0;
        bus.flush_b = 1'b1; bus.mode = 2'b00; bus.synch = 1'b0;
        bus.synch_pattern = 32'h5A5A0F0F; bus.n_act_lanes = 4'd4;
        bus.write_signal = 1'b0; bus.data_in = '0; bus.read_signal = 1'b0;
        bus.data_atu = '0;
        tick(); tick();

        // reset state
        chk("rst_lanes", bus.data_out, {4{I}});
        chk("rst_empty", 128'(bus.empty_signal), 128'd1);
        chk("rst_full", 128'(bus.full_signal), 128'd0);
        chk("rst_losing", 128'(bus.losing_data), 128'd0);
        chk("rst_drop", 128'(bus.drop_cnt), 128'd0);
        chk("rst_uflow", 128'(bus.underflow), 128'd0);
        rst_b = 1'b1;

        // DTU round-robin over 4 lanes: 8 pushes then 8 pops
        for (int i = 0; i < 8; i++) vt[i] = '{1'b1, 1'b0, 32'h10 + 32'(i), {4{I}}, 1'b0, 1'b0};
        vt[8]  = '{1'b0, 1'b1, 32'h0, lanes4(32'h10, I, I, I), 1'b0, 1'b0};
        vt[9]  = '{1'b0, 1'b1, 32'h0, lanes4(32'h10, 32'h11, I, I), 1'b0, 1'b0};
        vt[10] = '{1'b0, 1'b1, 32'h0, lanes4(32'h10, 32'h11, 32'h12, I), 1'b0, 1'b0};
        vt[11] = '{1'b0, 1'b1, 32'h0, lanes4(32'h10, 32'h11, 32'h12, 32'h13), 1'b0, 1'b0};
        vt[12] = '{1'b0, 1'b1, 32'h0, lanes4(32'h14, 32'h11, 32'h12, 32'h13), 1'b0, 1'b0};
        vt[13] = '{1'b0, 1'b1, 32'h0, lanes4(32'h14, 32'h15, 32'h12, 32'h13), 1'b0, 1'b0};
        vt[14] = '{1'b0, 1'b1, 32'h0, lanes4(32'h14, 32'h15, 32'h16, 32'h13), 1'b0, 1'b0};
        vt[15] = '{1'b0, 1'b1, 32'h0, lanes4(32'h14, 32'h15, 32'h16, 32'h17), 1'b1, 1'b0};
        for (int i = 0; i < 16; i++) begin
            bus.write_signal = vt[i].wr;
            bus.read_signal  = vt[i].rd;
            bus.data_in      = vt[i].din;
            tick();
            chk($sformatf("vec%0d_lanes", i), bus.data_out, vt[i].exp_lanes);
            chk($sformatf("vec%0d_empty", i), 128'(bus.empty_signal), 128'(vt[i].exp_empty));
            chk($sformatf("vec%0d_full", i), 128'(bus.full_signal), 128'(vt[i].exp_full));
        end
        bus.write_signal = 1'b0;
        bus.read_signal  = 1'b0;

        // asynchronous reset with five words queued
        for (int i = 0; i < 5; i++) push(32'h30 + 32'(i));
        #2 rst_b = 1'b0;
        #1;
        chk("async_rst_lanes", bus.data_out, {4{I}});
        chk("async_rst_empty", 128'(bus.empty_signal), 128'd1);
        tick();
        rst_b = 1'b1;

        // overflow: 18 writes into a 16-deep FIFO
        for (int i = 0; i < 18; i++) push(32'h100 + 32'(i));
        chk("ovf_full", 128'(bus.full_signal), 128'd1);
        chk("ovf_losing", 128'(bus.losing_data), 128'd1);
        chk("ovf_drop", 128'(bus.drop_cnt), 128'd2);
`ifdef LDTU_OSTAGE_ALMOST_FULL_EN
        chk("ovf_afull", 128'(bus.almost_full), 128'd1);
`endif
        bus.write_signal = 1'b1; bus.read_signal = 1'b1; bus.data_in = 32'hABC;
        tick();
        bus.write_signal = 1'b0; bus.read_signal = 1'b0;
        chk("ovf_wrpop_drop", 128'(bus.drop_cnt), 128'd2);
        chk("ovf_wrpop_full", 128'(bus.full_signal), 128'd1);
        chk("ovf_wrpop_lanes", bus.data_out, lanes4(32'h100, I, I, I));

        // underflow
        do_reset();
        pop();
        chk("uf_flag", 128'(bus.underflow), 128'd1);
        chk("uf_lanes", bus.data_out, {4{I}});
        do_reset();
        bus.write_signal = 1'b1; bus.read_signal = 1'b1; bus.data_in = 32'h55;
        tick();
        bus.write_signal = 1'b0; bus.read_signal = 1'b0;
        chk("uf_wrpop_flag", 128'(bus.underflow), 128'd1);
        chk("uf_wrpop_empty", 128'(bus.empty_signal), 128'd0);
        chk("uf_wrpop_lanes", bus.data_out, {4{I}});
        pop();
        chk("uf_after_lanes", bus.data_out, lanes4(32'h55, I, I, I));
        chk("uf_after_empty", 128'(bus.empty_signal), 128'd1);

        // active-lane changes
        do_reset();
        for (int i = 0; i < 8; i++) push(32'h20 + 32'(i));
        pop(); pop(); pop();
        chk("lc_three", bus.data_out, lanes4(32'h20, 32'h21, 32'h22, I));
        bus.n_act_lanes = 4'd2;
        pop();
        chk("lc_nact2", bus.data_out, lanes4(32'h23, 32'h21, I, I));
        bus.n_act_lanes = 4'd0;
        pop();
        chk("lc_nact0_a", bus.data_out, lanes4(32'h24, I, I, I));
        pop();
        chk("lc_nact0_b", bus.data_out, lanes4(32'h25, I, I, I));

        // overrides: synch blocks pops
        bus.synch = 1'b1; bus.read_signal = 1'b1;
        tick(); tick(); tick();
        bus.read_signal = 1'b0;
        chk("synch_lanes", bus.data_out, {4{32'h5A5A0F0F}});
        chk("synch_empty", 128'(bus.empty_signal), 128'd0);
        bus.synch = 1'b0; bus.n_act_lanes = 4'd4;
        tick();
        chk("dtu_entry_lanes", bus.data_out, {4{I}});
        pop(); pop();
        chk("dtu_resume_lanes", bus.data_out, lanes4(32'h26, 32'h27, I, I));
        chk("dtu_resume_empty", 128'(bus.empty_signal), 128'd1);
        chk("dtu_resume_uflow", 128'(bus.underflow), 128'd0);

        // ATU passthrough; reads ignored outside DTU
        bus.mode = 2'b01;
        bus.data_atu = lanes4(32'hA0A0_0000, 32'hA1A1_1111, 32'hA2A2_2222, 32'hA3A3_3333);
        bus.read_signal = 1'b1;
        tick();
        bus.read_signal = 1'b0;
        chk("atu_lanes", bus.data_out, lanes4(32'hA0A0_0000, 32'hA1A1_1111, 32'hA2A2_2222, 32'hA3A3_3333));
        chk("atu_uflow", 128'(bus.underflow), 128'd0);
        bus.mode = 2'b11;
        tick();
        chk("idle_lanes", bus.data_out, {4{I}});

        // flush clears flags and ignores a concurrent write
        bus.mode = 2'b00;
        pop();
        chk("pre_flush_uflow", 128'(bus.underflow), 128'd1);
        push(32'h77);
        chk("pre_flush_empty", 128'(bus.empty_signal), 128'd0);
        bus.flush_b = 1'b0; bus.write_signal = 1'b1; bus.data_in = 32'h88;
        tick();
        bus.flush_b = 1'b1; bus.write_signal = 1'b0;
        chk("flush_empty", 128'(bus.empty_signal), 128'd1);
        chk("flush_uflow", 128'(bus.underflow), 128'd0);
        chk("flush_lanes", bus.data_out, {4{I}});
        pop();
        chk("post_flush_uflow", 128'(bus.underflow), 128'd1);
        chk("post_flush_lanes", bus.data_out, {4{I}});

        // final report
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
